wb_obi_bridge: RTL and testbench

Wishbone classic slave to OBI primary bridge: converts single Caravel management-SoC Wishbone cycles within a configurable address window into single OBI transactions. It drives the primary port of the fast-primary OBI clock-domain crossing directly upstream. That crossing forwards address, write-enable, byte-enables and write data combinationally and returns grant and response late, so this bridge holds every OBI output stable from request until response. A timeout converts a hung transaction into a Wishbone error while the OBI side is drained safely.

---
 rtl/wb_obi_bridge.sv | 173 +++++++++++++++++
 tb/tb_wb_obi_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_obi_bridge.sv
// Wishbone classic slave to OBI primary bridge. Each Wishbone cycle that hits the
// address window becomes one OBI transaction, and a timeout turns a hung transaction into a Wishbone error.
module wb_obi_bridge #(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [31:0] wbs_dat_o,
    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    output logic        busy_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_THRESH = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REQ        = 3'd1,
        ST_RESP       = 3'd2,
        ST_ACK        = 3'd3,
        ST_DRAIN_REQ  = 3'd4,
        ST_DRAIN_RESP = 3'd5
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              abort_r;
    logic              ack_r;
    logic              err_r;
    logic [31:0]       rdata_r;
    logic              req_r;
    logic [31:0]       addr_r;
    logic              we_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic              busy_r;

    logic              match_s;
    logic              start_s;
    logic              abort_s;
    logic              expired_s;

    // Window decode, abort tracking and timeout threshold detection.
    always_comb begin
        match_s   = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
        start_s   = wbs_cyc_i & wbs_stb_i & match_s;
        abort_s   = abort_r | ~wbs_cyc_i;
        expired_s = 1'b0;
        if (TIMEOUT_CYCLES != 0) begin
            expired_s = (cnt_r >= CNT_THRESH);
        end else begin
            expired_s = 1'b0;
        end
    end

    // Bridge FSM with registered Wishbone and OBI outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            abort_r <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
            req_r   <= 1'b0;
            addr_r  <= 32'h0000_0000;
            we_r    <= 1'b0;
            be_r    <= 4'h0;
            wdata_r <= 32'h0000_0000;
            busy_r  <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        addr_r  <= wbs_adr_i;
                        we_r    <= wbs_we_i;
                        be_r    <= wbs_sel_i;
                        wdata_r <= wbs_dat_i;
                        // The acceptance cycle counts, so cycle k after acceptance sees a count of k.
                        cnt_r   <= CNT_ONE;
                        abort_r <= 1'b0;
                        req_r   <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    abort_r <= abort_s;
                    if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                    if (obi_gnt_i) begin
                        req_r   <= 1'b0;
                        state_r <= ST_RESP;
                    end else if (expired_s) begin
                        err_r   <= ~abort_s;
                        state_r <= ST_DRAIN_REQ;
                    end
                end
                ST_RESP: begin
                    abort_r <= abort_s;
                    if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                    if (obi_rvalid_i) begin
                        if (!we_r) begin
                            rdata_r <= obi_rdata_i;
                        end
                        ack_r   <= ~abort_s;
                        state_r <= ST_ACK;
                    end else if (expired_s) begin
                        err_r   <= ~abort_s;
                        state_r <= ST_DRAIN_RESP;
                    end
                end
                ST_ACK: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_DRAIN_REQ: begin
                    if (obi_gnt_i) begin
                        req_r   <= 1'b0;
                        state_r <= ST_DRAIN_RESP;
                    end
                end
                ST_DRAIN_RESP: begin
                    // The late response is swallowed; the Wishbone side already saw an error.
                    if (obi_rvalid_i) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    req_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o   = ack_r;
    assign wbs_err_o   = err_r;
    assign wbs_dat_o   = rdata_r;
    assign obi_req_o   = req_r;
    assign obi_addr_o  = addr_r;
    assign obi_we_o    = we_r;
    assign obi_be_o    = be_r;
    assign obi_wdata_o = wdata_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_wb_obi_bridge.sv
// Directed bench for wb_obi_bridge: reads, a slow write, an address miss, timeout
// draining, the threshold boundary, a Wishbone abort and reset in mid-transaction.
module tb_wb_obi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_adr, wbs_dat;
    logic        wbs_ack_o, wbs_err_o;
    logic [31:0] wbs_dat_o;
    logic        obi_req_o, obi_gnt;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;
    int n_ack;
    logic saw_req, saw_ack, saw_err;

    always #5 clk = ~clk;

    wb_obi_bridge #(
        .BASE_ADDR     (32'h3000_0000),
        .ADDR_MASK     (32'hFFFF_0000),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wbs_cyc_i   (wbs_cyc),
        .wbs_stb_i   (wbs_stb),
        .wbs_we_i    (wbs_we),
        .wbs_sel_i   (wbs_sel),
        .wbs_adr_i   (wbs_adr),
        .wbs_dat_i   (wbs_dat),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_err_o   (wbs_err_o),
        .wbs_dat_o   (wbs_dat_o),
        .obi_req_o   (obi_req_o),
        .obi_gnt_i   (obi_gnt),
        .obi_addr_o  (obi_addr_o),
        .obi_we_o    (obi_we_o),
        .obi_be_o    (obi_be_o),
        .obi_wdata_o (obi_wdata_o),
        .obi_rvalid_i(obi_rvalid),
        .obi_rdata_i (obi_rdata),
        .busy_o      (busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk1({pfx, "_ack"},   wbs_ack_o, 1'b0);
        chk1({pfx, "_err"},   wbs_err_o, 1'b0);
        chk ({pfx, "_dat"},   wbs_dat_o, 32'h0000_0000);
        chk1({pfx, "_req"},   obi_req_o, 1'b0);
        chk ({pfx, "_addr"},  obi_addr_o, 32'h0000_0000);
        chk1({pfx, "_we"},    obi_we_o, 1'b0);
        chk ({pfx, "_be"},    {28'd0, obi_be_o}, 32'h0000_0000);
        chk ({pfx, "_wdata"}, obi_wdata_o, 32'h0000_0000);
        chk1({pfx, "_busy"},  busy_o, 1'b0);
    endtask

    task automatic master_req(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                              input logic [31:0] dat);
        wbs_cyc = 1'b1;
        wbs_stb = 1'b1;
        wbs_we  = we;
        wbs_sel = sel;
        wbs_adr = adr;
        wbs_dat = dat;
    endtask

    task automatic master_idle();
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        wbs_we  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0; wbs_sel = 4'h0;
        wbs_adr = 32'h0000_0000; wbs_dat = 32'h0000_0000;
        obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = 32'h0000_0000;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // Zero-wait read: gnt in cycle 1, rvalid in cycle 2, ack in cycle 3.
        master_req(32'h3000_0010, 1'b0, 4'hF, 32'h0000_0000);
        tick();
        chk1("rd_req_c1", obi_req_o, 1'b1);
        chk ("rd_addr", obi_addr_o, 32'h3000_0010);
        chk1("rd_we", obi_we_o, 1'b0);
        chk1("rd_busy", busy_o, 1'b1);
        chk1("rd_ack_c1", wbs_ack_o, 1'b0);
        obi_gnt = 1'b1;
        tick();
        chk1("rd_req_c2", obi_req_o, 1'b0);
        chk1("rd_ack_c2", wbs_ack_o, 1'b0);
        obi_gnt = 1'b0; obi_rvalid = 1'b1; obi_rdata = 32'hDEAD_BEEF;
        tick();
        chk1("rd_ack_c3", wbs_ack_o, 1'b1);
        chk1("rd_err_c3", wbs_err_o, 1'b0);
        chk ("rd_dat", wbs_dat_o, 32'hDEAD_BEEF);
        obi_rvalid = 1'b0; obi_rdata = 32'h0000_0000;
        master_idle();
        tick();
        chk1("rd_ack_c4", wbs_ack_o, 1'b0);
        chk1("rd_busy_c4", busy_o, 1'b0);

        // Write against a slave on a 1/3-rate clock: gnt in cycle 3, rvalid in cycle 6.
        master_req(32'h3000_0004, 1'b1, 4'b0011, 32'h1234_5678);
        tick();
        n_ack = 0;
        for (int c = 1; c <= 8; c++) begin
            if (wbs_ack_o) n_ack++;
            chk1("wr_ack", wbs_ack_o, c == 7);
            chk1("wr_req", obi_req_o, c <= 3);
            chk1("wr_busy", busy_o, c <= 7);
            if (c <= 7) begin
                chk("wr_addr", obi_addr_o, 32'h3000_0004);
                chk1("wr_we", obi_we_o, 1'b1);
                chk("wr_be", {28'd0, obi_be_o}, 32'h0000_0003);
                chk("wr_wdata", obi_wdata_o, 32'h1234_5678);
            end
            obi_gnt    = (c == 3);
            obi_rvalid = (c == 6);
            obi_rdata  = 32'hFFFF_FFFF;
            if (c == 7) master_idle();
            tick();
        end
        chk("wr_ack_count", n_ack, 32'd1);
        chk("wr_dat_kept", wbs_dat_o, 32'hDEAD_BEEF);
        obi_gnt = 1'b0; obi_rvalid = 1'b0;

        // Address outside the window is ignored.
        master_req(32'h3001_0000, 1'b0, 4'hF, 32'h0000_0000);
        saw_req = 1'b0; saw_ack = 1'b0; saw_err = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            saw_req = saw_req | obi_req_o;
            saw_ack = saw_ack | wbs_ack_o;
            saw_err = saw_err | wbs_err_o;
        end
        master_idle();
        chk1("miss_req", saw_req, 1'b0);
        chk1("miss_ack", saw_ack, 1'b0);
        chk1("miss_err", saw_err, 1'b0);
        tick();

        // Timeout in REQ, drain, and a second request held off until IDLE at cycle 26.
        master_req(32'h3000_0030, 1'b0, 4'hF, 32'h0000_0000);
        tick();
        for (int c = 1; c <= 27; c++) begin
            chk1("to_err", wbs_err_o, c == 8);
            chk1("to_ack", wbs_ack_o, 1'b0);
            chk1("to_req", obi_req_o, (c <= 20) || (c == 27));
            chk1("to_busy", busy_o, c != 26);
            chk("to_addr", obi_addr_o, (c == 27) ? 32'h3000_0020 : 32'h3000_0030);
            if (c == 26) chk("to_dat_kept", wbs_dat_o, 32'hDEAD_BEEF);
            obi_gnt    = (c == 20) || (c == 27);
            obi_rvalid = (c == 25);
            obi_rdata  = 32'h5555_AAAA;
            if (c == 9)  master_idle();
            if (c == 12) master_req(32'h3000_0020, 1'b0, 4'hF, 32'h0000_0000);
            tick();
        end
        chk1("to2_req_c2", obi_req_o, 1'b0);
        obi_gnt = 1'b0; obi_rvalid = 1'b1; obi_rdata = 32'hA5A5_5A5A;
        tick();
        chk1("to2_ack", wbs_ack_o, 1'b1);
        chk ("to2_dat", wbs_dat_o, 32'hA5A5_5A5A);
        obi_rvalid = 1'b0;
        master_idle();
        tick();

        // Grant in exactly the threshold cycle: no error, normal completion.
        master_req(32'h3000_0050, 1'b0, 4'hF, 32'h0000_0000);
        tick();
        for (int c = 1; c <= 10; c++) begin
            chk1("bnd_err", wbs_err_o, 1'b0);
            chk1("bnd_ack", wbs_ack_o, c == 9);
            chk1("bnd_req", obi_req_o, c <= 7);
            if (c == 9)  chk("bnd_dat", wbs_dat_o, 32'h0BAD_F00D);
            if (c == 10) chk1("bnd_busy", busy_o, 1'b0);
            obi_gnt    = (c == 7);
            obi_rvalid = (c == 8);
            obi_rdata  = 32'h0BAD_F00D;
            if (c == 9) master_idle();
            tick();
        end
        obi_gnt = 1'b0; obi_rvalid = 1'b0;

        // cyc dropped in RESP: OBI side completes, no ack and no error.
        master_req(32'h3000_0060, 1'b0, 4'hF, 32'h0000_0000);
        tick();
        for (int c = 1; c <= 6; c++) begin
            chk1("abt_ack", wbs_ack_o, 1'b0);
            chk1("abt_err", wbs_err_o, 1'b0);
            chk1("abt_busy", busy_o, c <= 5);
            obi_gnt    = (c == 1);
            obi_rvalid = (c == 4);
            obi_rdata  = 32'h1111_2222;
            if (c == 2) master_idle();
            tick();
        end
        obi_gnt = 1'b0; obi_rvalid = 1'b0;

        // Reset pulsed in RESP clears every output at once; the next read works.
        master_req(32'h3000_0070, 1'b1, 4'hC, 32'h9999_8888);
        tick();
        chk1("mr_req_c1", obi_req_o, 1'b1);
        obi_gnt = 1'b1;
        tick();
        obi_gnt = 1'b0;
        chk1("mr_busy_pre", busy_o, 1'b1);
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        master_idle();
        tick();
        rst = 1'b0;
        tick();
        master_req(32'h3000_0080, 1'b0, 4'hF, 32'h0000_0000);
        tick();
        chk1("post_req_c1", obi_req_o, 1'b1);
        chk ("post_addr", obi_addr_o, 32'h3000_0080);
        obi_gnt = 1'b1;
        tick();
        obi_gnt = 1'b0; obi_rvalid = 1'b1; obi_rdata = 32'hCAFE_F00D;
        tick();
        chk1("post_ack", wbs_ack_o, 1'b1);
        chk ("post_dat", wbs_dat_o, 32'hCAFE_F00D);
        obi_rvalid = 1'b0;
        master_idle();
        tick();
        chk1("post_ack_end", wbs_ack_o, 1'b0);
        chk1("post_busy_end", busy_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
